// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock keypad path: key codes, scanner states
// and the row/column to digit keymap.
package alarm_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t NOKEY = 4'd10;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} kp_state_t;

  // Keypad layout 1 2 3 / 4 5 6 / 7 8 9 / * 0 #; '*' and '#' are not keys.
  function automatic key_code_t keymap(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    code = NOKEY;
    if (row == 2'd3) begin
      if (col == 2'd1) code = 4'd0;
    end else if (col != 2'd3) begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// Two-flop synchroniser bringing the asynchronous keypad columns into the clock domain.
module kp_col_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alarm_keypad_scanner.sv
// 4x3 keypad scanner: rotates a one-hot row drive, debounces a single digit press
// and presents one stable key code per press to the alarm-clock FSM.
module alarm_keypad_scanner
  import alarm_pkg::*;
#(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output key_code_t  key,
  output logic       key_press
);

  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       col_s;
  kp_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]       row_next, row_rot;
  logic [1:0]       row_idx, col_idx, cap_col, cap_next;
  key_code_t        key_next;
  logic             press_next;
  logic             col_onehot;
  logic [2:0]       cap_mask;

  kp_col_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (col_in),
    .q     (col_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      row_out   <= 4'b0001;
      cap_col   <= 2'd0;
      key       <= NOKEY;
      key_press <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      row_out   <= row_next;
      cap_col   <= cap_next;
      key       <= key_next;
      key_press <= press_next;
    end
  end

  always_comb begin
    case (row_out)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    col_idx    = col_s[2] ? 2'd2 : (col_s[1] ? 2'd1 : 2'd0);
    col_onehot = (col_s == 3'b001) || (col_s == 3'b010) || (col_s == 3'b100);
    cap_mask   = 3'b001 << cap_col;
    cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    row_rot    = {row_out[2:0], row_out[3]};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    row_next   = row_out;
    cap_next   = cap_col;
    key_next   = key;
    press_next = 1'b0;

    case (state)
      SCAN: begin
        if (cnt == DWELL_LAST) begin
          cnt_next = '0;
          if (col_onehot && keymap(row_idx, col_idx) != NOKEY) begin
            cap_next   = col_idx;
            state_next = DEB_PRESS;
          end else begin
            row_next = row_rot;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      // The capture sample counts as the first of the DEBOUNCE_CYCLES samples.
      DEB_PRESS: begin
        if (col_s == cap_mask) begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            cnt_next   = '0;
            state_next = PRESSED;
            key_next   = keymap(row_idx, cap_col);
            press_next = 1'b1;
          end
        end else begin
          cnt_next   = '0;
          state_next = SCAN;
          row_next   = row_rot;
        end
      end

      PRESSED: begin
        if (!col_s[cap_col]) begin
          cnt_next   = '0;
          state_next = DEB_REL;
        end
      end

      DEB_REL: begin
        if (!col_s[cap_col]) begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            cnt_next   = '0;
            state_next = SCAN;
            key_next   = NOKEY;
            row_next   = row_rot;
          end
        end else begin
          cnt_next   = '0;
          state_next = PRESSED;
        end
      end

      default: begin
        state_next = SCAN;
        cnt_next   = '0;
        row_next   = 4'b0001;
      end
    endcase
  end

endmodule
